fetch_stage: RTL and testbench

// Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core.

---
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RISC-V core.
// One action per edge, priority FLUSH > STALL > RUN; saturating flush/stall event counters.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             if_flush_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    output logic [XLEN-1:0]  ifid_pc_o,
    output logic [XLEN-1:0]  ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_ifid_pc;
    logic [XLEN-1:0]  r_ifid_pc4;
    logic [31:0]      r_ifid_instr;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_stall_evt;

    // pc+4 wraps naturally at the top of the address space.
    assign w_pc_plus4    = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
    // A flush overrides a stall, so such a cycle is not counted as a stall.
    assign w_stall_evt   = stall_i & ~if_flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc         <= RESET_PC;
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (if_flush_i) begin
            r_pc         <= w_redirect_pc;
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (!stall_i) begin
            r_pc         <= w_pc_plus4;
            r_ifid_pc    <= r_pc;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_instr <= imem_rdata_i;
            r_ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (if_flush_i && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_stall_evt && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign imem_addr_o  = r_pc;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_valid_o = r_ifid_valid;
    assign flush_cnt_o  = r_flush_cnt;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected post-edge state is queued by the driver and
// checked by an independent monitor one time unit after each rising edge.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifid_pc;
        logic [31:0] ifid_pc4;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] fcnt;
        logic [15:0] scnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [15:0] flush_cnt;
    logic [15:0] stall_cnt;

    logic        b_rst_n;
    logic        b_stall;
    logic        b_flush;
    logic [31:0] b_redirect;
    logic [31:0] b_imem_addr;
    logic [31:0] b_imem_rdata;
    logic [31:0] b_ifid_pc;
    logic [31:0] b_ifid_pc4;
    logic [31:0] b_ifid_instr;
    logic        b_ifid_valid;
    logic [3:0]  b_flush_cnt;
    logic [3:0]  b_stall_cnt;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Instruction memory model: word at address A reads as 0xA0 + A.
    assign imem_rdata   = 32'h0000_00A0 + imem_addr;
    assign b_imem_rdata = 32'h0000_00A0 + b_imem_addr;

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .stall_i       (stall),
        .if_flush_i    (flush),
        .redirect_pc_i (redirect),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_instr_o  (ifid_instr),
        .ifid_valid_o  (ifid_valid),
        .flush_cnt_o   (flush_cnt),
        .stall_cnt_o   (stall_cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut_b (
        .clk_i         (clk),
        .rst_i         (b_rst_n),
        .stall_i       (b_stall),
        .if_flush_i    (b_flush),
        .redirect_pc_i (b_redirect),
        .imem_addr_o   (b_imem_addr),
        .imem_rdata_i  (b_imem_rdata),
        .ifid_pc_o     (b_ifid_pc),
        .ifid_pc4_o    (b_ifid_pc4),
        .ifid_instr_o  (b_ifid_instr),
        .ifid_valid_o  (b_ifid_valid),
        .flush_cnt_o   (b_flush_cnt),
        .stall_cnt_o   (b_stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ipc,
                                input logic [31:0] ipc4, input logic [31:0] instr,
                                input logic v, input logic [15:0] fc, input logic [15:0] sc);
        exp_t e;
        e.pc = pc; e.ifid_pc = ipc; e.ifid_pc4 = ipc4; e.instr = instr;
        e.valid = v; e.fcnt = fc; e.scnt = sc;
        return e;
    endfunction

    // Driver: apply inputs for the coming edge, queue the expected post-edge state.
    task automatic drive(input logic st, input logic fl, input logic [31:0] rd, input exp_t e);
        stall    = st;
        flush    = fl;
        redirect = rd;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("pc",        imem_addr,          mon_e.pc);
            chk("ifid_pc",   ifid_pc,            mon_e.ifid_pc);
            chk("ifid_pc4",  ifid_pc4,           mon_e.ifid_pc4);
            chk("ifid_ins",  ifid_instr,         mon_e.instr);
            chk("ifid_vld",  {31'd0, ifid_valid}, {31'd0, mon_e.valid});
            chk("flush_cnt", {16'd0, flush_cnt},  {16'd0, mon_e.fcnt});
            chk("stall_cnt", {16'd0, stall_cnt},  {16'd0, mon_e.scnt});
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = '0;
        b_rst_n = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_redirect = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        // Asynchronous reset asserted mid-cycle, checked before any further edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_pc",    imem_addr,            32'h0);
        chk("rst_ipc",   ifid_pc,              32'h0);
        chk("rst_ipc4",  ifid_pc4,             32'h0);
        chk("rst_instr", ifid_instr,           32'h0000_0013);
        chk("rst_valid", {31'd0, ifid_valid},  32'h0);
        chk("rst_fcnt",  {16'd0, flush_cnt},   32'h0);
        chk("rst_scnt",  {16'd0, stall_cnt},   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //          stall flush redirect       pc            ifid_pc       ifid_pc4      instr         v  fc  sc
        drive(1'b0, 1'b0, 32'h0,         mk(32'h4,        32'h0,        32'h4,        32'hA0,       1, 0, 0));
        drive(1'b0, 1'b0, 32'h0,         mk(32'h8,        32'h4,        32'h8,        32'hA4,       1, 0, 0));
        drive(1'b1, 1'b0, 32'h0,         mk(32'h8,        32'h4,        32'h8,        32'hA4,       1, 0, 1));
        drive(1'b1, 1'b0, 32'h0,         mk(32'h8,        32'h4,        32'h8,        32'hA4,       1, 0, 2));
        drive(1'b1, 1'b0, 32'h0,         mk(32'h8,        32'h4,        32'h8,        32'hA4,       1, 0, 3));
        drive(1'b0, 1'b0, 32'h0,         mk(32'hC,        32'h8,        32'hC,        32'hA8,       1, 0, 3));
        drive(1'b0, 1'b0, 32'h0,         mk(32'h10,       32'hC,        32'h10,       32'hAC,       1, 0, 3));
        drive(1'b0, 1'b1, 32'h103,       mk(32'h100,      32'h0,        32'h0,        32'h13,       0, 1, 3));
        drive(1'b0, 1'b0, 32'h0,         mk(32'h104,      32'h100,      32'h104,      32'h1A0,      1, 1, 3));
        drive(1'b0, 1'b0, 32'h0,         mk(32'h108,      32'h104,      32'h108,      32'h1A4,      1, 1, 3));
        drive(1'b1, 1'b1, 32'h40,        mk(32'h40,       32'h0,        32'h0,        32'h13,       0, 2, 3));
        drive(1'b0, 1'b1, 32'h201,       mk(32'h200,      32'h0,        32'h0,        32'h13,       0, 3, 3));
        drive(1'b0, 1'b0, 32'h0,         mk(32'h204,      32'h200,      32'h204,      32'h2A0,      1, 3, 3));
        drive(1'b1, 1'b0, 32'h0,         mk(32'h204,      32'h200,      32'h204,      32'h2A0,      1, 3, 4));
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, mk(32'hFFFF_FFFC, 32'h0,       32'h0,        32'h13,       0, 4, 4));
        drive(1'b0, 1'b0, 32'h0,         mk(32'h0,        32'hFFFF_FFFC, 32'h0,       32'h9C,       1, 4, 4));
        stall = 1'b1;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        // Second instance: non-zero reset PC wrapping and 4-bit counter saturation.
        b_rst_n = 1'b1;
        #1;
        chk("b_rst_pc",  b_imem_addr,           32'hFFFF_FFFC);
        chk("b_rst_vld", {31'd0, b_ifid_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("b_wrap_pc",   b_imem_addr,  32'h0);
        chk("b_wrap_ipc",  b_ifid_pc,    32'hFFFF_FFFC);
        chk("b_wrap_ipc4", b_ifid_pc4,   32'h0);
        chk("b_wrap_ins",  b_ifid_instr, 32'h9C);
        b_flush = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("b_fcnt14", {28'd0, b_flush_cnt}, 32'hE);
        repeat (6) @(posedge clk);
        #1;
        chk("b_fcnt20", {28'd0, b_flush_cnt}, 32'hF);
        chk("b_scnt",   {28'd0, b_stall_cnt}, 32'h0);
        chk("b_fl_vld", {31'd0, b_ifid_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
